bytes_to_bits_stream_ctrl: RTL and testbench

//  Sequential controller for byte-to-bit unpacking (Kyber BytesToBits, LSB-first).

---
 rtl/bytes_to_bits_stream_ctrl_pkg.sv | 18 +
 rtl/bytes_to_bits_stream_ctrl_if.sv | 27 ++
 rtl/bytes_to_bits_stream_ctrl_bitbuf.sv | 51 +++++
 rtl/bytes_to_bits_stream_ctrl.sv | 92 +++++++++
 tb/tb_bytes_to_bits_stream_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/bytes_to_bits_stream_ctrl_pkg.sv
// Shared types and widths for the Kyber BytesToBits unpacker.
// BYTES_TO_BITS_FLUSH_EN: when defined, residual bits at job end go out as a zero-padded last group.
package kyber_b2b_pkg;

    typedef enum logic [1:0] {B2B_IDLE, B2B_RUN, B2B_FLUSH, B2B_DONE} b2b_state_e;

    localparam int unsigned BUF_W  = 16;
    localparam int unsigned FILL_W = 5;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LEN_W  = 8;

`ifdef BYTES_TO_BITS_FLUSH_EN
    localparam bit B2B_FLUSH_EN = 1'b1;
`else
    localparam bit B2B_FLUSH_EN = 1'b0;
`endif

endpackage

// File: rtl/bytes_to_bits_stream_ctrl_if.sv
// Job control, byte input stream and bit-group output stream of the unpacker.
interface bytes_to_bits_stream_ctrl_if #(parameter int unsigned OUT_W = 3);
    import kyber_b2b_pkg::*;

    logic              start;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] in_byte;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        output start, len, in_valid, in_byte, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        input  start, len, in_valid, in_byte, out_ready,
        output in_ready, out_valid, out_data, out_last, busy, done
    );

endinterface

// File: rtl/bytes_to_bits_stream_ctrl_bitbuf.sv
// LSB-first shift buffer: pops OUT_W bits from the bottom, inserts whole bytes just above the valid bits.
module b2b_bitbuf
    import kyber_b2b_pkg::*;
#(
    parameter int unsigned OUT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [OUT_W-1:0]  data_o,
    output logic [FILL_W-1:0] fill_o
);

    localparam logic [FILL_W-1:0] POP_N  = FILL_W'(OUT_W);
    localparam logic [FILL_W-1:0] PUSH_N = FILL_W'(BYTE_W);

    logic [BUF_W-1:0]  data_q, data_d;
    logic [BUF_W-1:0]  shifted, ins;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [FILL_W-1:0] ins_at;

    // A same-cycle pop moves the insert point down so no bit is lost or repeated.
    always_comb begin
        shifted = pop_i ? (data_q >> OUT_W) : data_q;
        ins_at  = pop_i ? (fill_q - POP_N) : fill_q;
        ins     = push_i ? (BUF_W'(byte_i) << ins_at) : '0;
        data_d  = shifted | ins;
        fill_d  = fill_q + (push_i ? PUSH_N : '0) - (pop_i ? POP_N : '0);
        if (clr_i) begin
            data_d = '0;
            fill_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            fill_q <= '0;
        end else begin
            data_q <= data_d;
            fill_q <= fill_d;
        end
    end

    assign data_o = data_q[OUT_W-1:0];
    assign fill_o = fill_q;

endmodule

// File: rtl/bytes_to_bits_stream_ctrl.sv
// Kyber BytesToBits job controller: len bytes in, OUT_W-bit LSB-first groups out.
// BYTES_TO_BITS_FLUSH_EN selects emitting (defined) or dropping (undefined) the residual bits.
module bytes_to_bits_stream_ctrl
    import kyber_b2b_pkg::*;
#(
    parameter int unsigned OUT_W = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    bytes_to_bits_stream_ctrl_if.slave   bus
);

    localparam logic [FILL_W-1:0] GRP_N   = FILL_W'(OUT_W);
    localparam logic [FILL_W-1:0] GRP2_N  = FILL_W'(2 * OUT_W);
    localparam logic [FILL_W-1:0] IN_ROOM = FILL_W'(BUF_W - BYTE_W);

    b2b_state_e        state_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  bytes_in_q;
    logic              done_q;

    logic [OUT_W-1:0]  grp_data;
    logic [FILL_W-1:0] fill;
    logic              in_ready_c, run_vld, flush_vld, all_in, last_full;
    logic              push, pop, clr;

    assign all_in     = (bytes_in_q == len_q);
    assign in_ready_c = (state_q == B2B_RUN) && (bytes_in_q < len_q) && (fill <= IN_ROOM);
    assign run_vld    = (state_q == B2B_RUN) && (fill >= GRP_N);
    assign flush_vld  = B2B_FLUSH_EN && (state_q == B2B_FLUSH) && (fill != '0);

    // Last full group: nothing left over when flushing, otherwise fewer than OUT_W bits remain after it.
    assign last_full  = B2B_FLUSH_EN ? (fill == GRP_N) : (fill < GRP2_N);

    assign push = bus.in_valid && in_ready_c;
    assign pop  = run_vld && bus.out_ready;
    assign clr  = !((state_q == B2B_RUN) || (flush_vld && !bus.out_ready));

    b2b_bitbuf #(.OUT_W(OUT_W)) u_bitbuf (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .push_i (push),
        .pop_i  (pop),
        .byte_i (bus.in_byte),
        .data_o (grp_data),
        .fill_o (fill)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= B2B_IDLE;
            len_q      <= '0;
            bytes_in_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state_q == B2B_DONE);
            case (state_q)
                B2B_IDLE: begin
                    if (bus.start) begin
                        len_q      <= bus.len;
                        bytes_in_q <= '0;
                        state_q    <= (bus.len == '0) ? B2B_DONE : B2B_RUN;
                    end
                end
                B2B_RUN: begin
                    if (push) begin
                        bytes_in_q <= bytes_in_q + LEN_W'(1);
                    end
                    if (all_in && (fill < GRP_N)) begin
                        state_q <= B2B_FLUSH;
                    end
                end
                B2B_FLUSH: begin
                    if (!flush_vld || bus.out_ready) begin
                        state_q <= B2B_DONE;
                    end
                end
                B2B_DONE: state_q <= B2B_IDLE;
                default:  state_q <= B2B_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = run_vld || flush_vld;
    assign bus.out_data  = grp_data;
    assign bus.out_last  = flush_vld || (run_vld && all_in && last_full);
    assign bus.busy      = (state_q != B2B_IDLE);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_bytes_to_bits_stream_ctrl.sv
// Directed bench for bytes_to_bits_stream_ctrl with OUT_W=3 and OUT_W=4 instances.
module tb_bytes_to_bits_stream_ctrl;
    import kyber_b2b_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bytes_to_bits_stream_ctrl_if #(.OUT_W(3)) b3 ();
    bytes_to_bits_stream_ctrl_if #(.OUT_W(4)) b4 ();

    bytes_to_bits_stream_ctrl #(.OUT_W(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));
    bytes_to_bits_stream_ctrl #(.OUT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    int total = 0;
    int bad   = 0;

    logic [7:0] din [32];
    logic [7:0] grp_q [$];
    logic       last_q [$];
    int         done_cnt, acc_cnt, stab_err, seen_at;

    logic [7:0] t3_head [8] = '{8'hFF, 8'h00, 8'hEF, 8'h01, 8'hFF, 8'hFF, 8'h67, 8'h89};
    logic [7:0] t2_exp  [6] = '{8'h7, 8'h7, 8'h3, 8'h0, 8'h0, 8'h0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Bits [k*w +: w] of the LSB-first bit string of din[0..L-1], zero beyond the end.
    function automatic logic [7:0] exp_grp(input int k, input int w, input int L);
        logic [7:0] g = '0;
        logic [7:0] byt;
        for (int i = 0; i < w; i++) begin
            int pos = k * w + i;
            if (pos < 8 * L) begin
                byt  = din[pos / 8];
                g[i] = byt[pos % 8];
            end
        end
        return g;
    endfunction

    // One job on the OUT_W=3 instance; optional random backpressure and a start poke mid-run.
    task automatic run3(input int L, input bit stall, input bit poke);
        int         idx = 0;
        bit         prev_stall = 1'b0;
        logic [2:0] prev_data = '0;
        grp_q.delete();
        last_q.delete();
        done_cnt = 0;
        stab_err = 0;
        seen_at  = -1;
        @(negedge clk);
        b3.start = 1'b1;
        b3.len   = 8'(L);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            b3.start     = poke && (cyc == 4);
            b3.len       = (poke && (cyc == 4)) ? 8'd5 : 8'(L);
            b3.in_valid  = (idx < L);
            b3.in_byte   = (idx < L) ? din[idx] : 8'h00;
            b3.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall && ((b3.out_valid !== 1'b1) || (b3.out_data !== prev_data))) stab_err++;
            prev_stall = b3.out_valid && !b3.out_ready;
            prev_data  = b3.out_data;
            if (b3.in_valid && b3.in_ready) idx++;
            if (b3.out_valid && b3.out_ready) begin
                grp_q.push_back(8'(b3.out_data));
                last_q.push_back(b3.out_last);
            end
            if (b3.done === 1'b1) begin
                done_cnt++;
                if (seen_at < 0) seen_at = cyc;
            end
            if ((seen_at >= 0) && (cyc >= seen_at + 4)) break;
        end
        acc_cnt      = idx;
        b3.start     = 1'b0;
        b3.in_valid  = 1'b0;
        b3.out_ready = 1'b0;
        check("job_finished", 32'(seen_at >= 0), 32'd1);
    endtask

    task automatic check_t2(input string tag);
        int n = 5 + int'(B2B_FLUSH_EN);
        check({tag, "_count"}, 32'(grp_q.size()), 32'(n));
        for (int k = 0; k < n && k < grp_q.size(); k++) begin
            check($sformatf("%s_grp%0d", tag, k), 32'(grp_q[k]), 32'(t2_exp[k]));
            check($sformatf("%s_last%0d", tag, k), 32'(last_q[k]), 32'(k == n - 1));
        end
        check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
        check({tag, "_bytes"}, 32'(acc_cnt), 32'd2);
    endtask

    initial begin
        int n, done_at, rdy, vld, idx;
        rst = 1'b1;
        b3.start = 1'b0; b3.len = '0; b3.in_valid = 1'b0; b3.in_byte = '0; b3.out_ready = 1'b0;
        b4.start = 1'b0; b4.len = '0; b4.in_valid = 1'b0; b4.in_byte = '0; b4.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_outs3", 32'({b3.in_ready, b3.out_valid, b3.out_last, b3.busy, b3.done, b3.out_data}), 32'd0);
        check("rst_outs4", 32'({b4.in_ready, b4.out_valid, b4.out_last, b4.busy, b4.done, b4.out_data}), 32'd0);
        rst = 1'b0;

        // T1: OUT_W=4, single byte 0xA5 -> 0x5 then 0xA(last)
        @(negedge clk);
        b4.start = 1'b1; b4.len = 8'd1;
        @(negedge clk);
        b4.start = 1'b0; b4.in_valid = 1'b1; b4.in_byte = 8'hA5; b4.out_ready = 1'b1;
        check("t1_busy", 32'(b4.busy), 32'd1);
        check("t1_in_ready", 32'(b4.in_ready), 32'd1);
        @(negedge clk);
        b4.in_valid = 1'b0;
        check("t1_g0", 32'({b4.out_valid, b4.out_last, b4.out_data}), 32'h25);
        check("t1_in_ready_after", 32'(b4.in_ready), 32'd0);
        @(negedge clk);
        check("t1_g1", 32'({b4.out_valid, b4.out_last, b4.out_data}), 32'h3A);
        @(negedge clk);
        check("t1_drained", 32'(b4.out_valid), 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (b4.done === 1'b1) begin
                done_cnt++;
                check("t1_busy_at_done", 32'(b4.busy), 32'd0);
            end
        end
        check("t1_done_once", 32'(done_cnt), 32'd1);
        b4.out_ready = 1'b0;

        // T2: OUT_W=3, FF,00
        din[0] = 8'hFF; din[1] = 8'h00;
        run3(2, 1'b0, 1'b0);
        check_t2("t2");

        // T3: 32 bytes with random backpressure
        for (int j = 0; j < 32; j++) din[j] = (j < 8) ? t3_head[j] : 8'(j * 29 + 7);
        run3(32, 1'b1, 1'b0);
        n = 85 + int'(B2B_FLUSH_EN);
        check("t3_count", 32'(grp_q.size()), 32'(n));
        for (int k = 0; k < n && k < grp_q.size(); k++) begin
            check($sformatf("t3_grp%0d", k), 32'(grp_q[k]), 32'(exp_grp(k, 3, 32)));
            check($sformatf("t3_last%0d", k), 32'(last_q[k]), 32'(k == n - 1));
        end
        check("t3_stable", 32'(stab_err), 32'd0);
        check("t3_done_once", 32'(done_cnt), 32'd1);

        // T4: len=0
        @(negedge clk);
        b3.start = 1'b1; b3.len = 8'd0; b3.in_valid = 1'b1; b3.in_byte = 8'h5A; b3.out_ready = 1'b1;
        done_at = -1; rdy = 0; vld = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            b3.start = 1'b0;
            if (b3.in_ready === 1'b1) rdy++;
            if (b3.out_valid === 1'b1) vld++;
            if ((b3.done === 1'b1) && (done_at < 0)) done_at = k;
        end
        b3.in_valid = 1'b0; b3.out_ready = 1'b0;
        check("t4_in_ready", 32'(rdy), 32'd0);
        check("t4_out_valid", 32'(vld), 32'd0);
        check("t4_done_at", 32'(done_at), 32'd2);

        // T5: async reset after 3 accepted bytes, then a clean job
        for (int j = 0; j < 8; j++) din[j] = 8'(8'h31 + j);
        @(negedge clk);
        b3.start = 1'b1; b3.len = 8'd8;
        idx = 0;
        for (int c = 0; c < 50 && idx < 3; c++) begin
            @(negedge clk);
            b3.start = 1'b0; b3.in_valid = 1'b1; b3.in_byte = din[idx]; b3.out_ready = 1'b1;
            if (b3.in_ready === 1'b1) idx++;
        end
        check("t5_three_bytes", 32'(idx), 32'd3);
        @(posedge clk);
        #2;
        check("t5_busy_before", 32'(b3.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_outs_rst", 32'({b3.in_ready, b3.out_valid, b3.out_last, b3.busy, b3.done, b3.out_data}), 32'd0);
        b3.in_valid = 1'b0; b3.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        din[0] = 8'hFF; din[1] = 8'h00;
        run3(2, 1'b0, 1'b0);
        check_t2("t5");

        // T6: start with len=5 during RUN must be ignored
        run3(2, 1'b0, 1'b1);
        check_t2("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
